// File: rtl/multicycle_controller.sv
// Multicycle RISC-V sequencing FSM: steps instructions through shared-memory phases
// and drives datapath selects, write enables and ALU operation from the current state.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               GE,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic [2:0]         ImmSrc,
    output logic [3:0]         ALUControl,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] fn_alu;
    logic       taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = STATE_W'(state_q);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BR:        state_d = BRANCH;
                    OP_LUI:       state_d = LUI;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD: state_d = MEMWB;
            EXECR, EXECI, JAL, LUI: state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Only R-type subtracts on funct7b5; for I-type that bit is immediate data.
    always_comb begin
        fn_alu = ALU_ADD;
        case (funct3)
            3'b000: fn_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: fn_alu = ALU_SLL;
            3'b010: fn_alu = ALU_SLT;
            3'b011: fn_alu = ALU_SLTU;
            3'b100: fn_alu = ALU_XOR;
            3'b101: fn_alu = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: fn_alu = ALU_OR;
            default: fn_alu = ALU_AND;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = ~GE;
            3'b101:  taken = GE;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = fn_alu;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = fn_alu;
            end
            ALUWB: RegWrite = 1'b1;
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = taken;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
        // Reset abandons the instruction immediately, not at the next edge.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and checks every output against hand-computed rows.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       GE;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] state;

    int nerr;
    int nchk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .Zero(Zero),
        .GE(GE),
        .PCWrite(PCWrite),
        .AdrSrc(AdrSrc),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite),
        .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Row layout: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
    // ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl.
    task automatic look(input string tag, input logic [3:0] st,
                        input logic pcw, input logic adr, input logic mw,
                        input logic irw, input logic [1:0] rs,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input logic rw, input logic [2:0] imm,
                        input logic [3:0] alu);
        logic [21:0] obs;
        logic [21:0] exp;
        #1;
        obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl};
        exp = {st, pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu};
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st,
                       input logic pcw, input logic adr, input logic mw,
                       input logic irw, input logic [1:0] rs,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic rw, input logic [2:0] imm,
                       input logic [3:0] alu);
        look(tag, st, pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu);
        tick();
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic z, input logic ge);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        GE       = ge;
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        reset = 1'b1;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);

        // reset held two cycles
        tick();
        look("rst1", 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        tick();
        look("rst2", 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        reset = 1'b0;

        // lw
        cyc("lw_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        cyc("lw_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b000, 4'h0);
        cyc("lw_ma", 4'd2, 0,0,0,0, 2'b00,2'b10,2'b01, 0, 3'b000, 4'h0);
        cyc("lw_mr", 4'd3, 0,1,0,0, 2'b00,2'b00,2'b00, 0, 3'b000, 4'h0);
        cyc("lw_wb", 4'd4, 0,0,0,0, 2'b01,2'b00,2'b00, 1, 3'b000, 4'h0);

        // R-type sub
        set_in(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc("sub_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        cyc("sub_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b000, 4'h0);
        cyc("sub_ex", 4'd6, 0,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b000, 4'h1);
        cyc("sub_wb", 4'd7, 0,0,0,0, 2'b00,2'b00,2'b00, 1, 3'b000, 4'h0);

        // R-type sra
        set_in(7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc("sra_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        cyc("sra_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b000, 4'h0);
        cyc("sra_ex", 4'd6, 0,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b000, 4'h8);
        cyc("sra_wb", 4'd7, 0,0,0,0, 2'b00,2'b00,2'b00, 1, 3'b000, 4'h0);

        // R-type and
        set_in(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0);
        cyc("and_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        cyc("and_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b000, 4'h0);
        cyc("and_ex", 4'd6, 0,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b000, 4'h2);
        cyc("and_wb", 4'd7, 0,0,0,0, 2'b00,2'b00,2'b00, 1, 3'b000, 4'h0);

        // addi with funct7b5=1 stays add
        set_in(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc("addi_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        cyc("addi_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b000, 4'h0);
        cyc("addi_ex", 4'd8, 0,0,0,0, 2'b00,2'b10,2'b01, 0, 3'b000, 4'h0);
        cyc("addi_wb", 4'd7, 0,0,0,0, 2'b00,2'b00,2'b00, 1, 3'b000, 4'h0);

        // srli and sltiu
        set_in(7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cyc("srli_ex", 4'd8, 0,0,0,0, 2'b00,2'b10,2'b01, 0, 3'b000, 4'h7);
        tick();
        set_in(7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cyc("sltiu_ex", 4'd8, 0,0,0,0, 2'b00,2'b10,2'b01, 0, 3'b000, 4'h9);
        tick();

        // lui
        set_in(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc("lui_f",  4'd0,  1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b100, 4'h0);
        cyc("lui_d",  4'd1,  0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b100, 4'h0);
        cyc("lui_ex", 4'd11, 0,0,0,0, 2'b00,2'b11,2'b01, 0, 3'b100, 4'h0);
        cyc("lui_wb", 4'd7,  0,0,0,0, 2'b00,2'b00,2'b00, 1, 3'b100, 4'h0);

        // jal
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc("jal_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b011, 4'h0);
        cyc("jal_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b011, 4'h0);
        cyc("jal_j",  4'd9, 1,0,0,0, 2'b00,2'b01,2'b10, 0, 3'b011, 4'h0);
        cyc("jal_wb", 4'd7, 0,0,0,0, 2'b00,2'b00,2'b00, 1, 3'b011, 4'h0);

        // beq taken
        set_in(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
        cyc("beq1_f", 4'd0,  1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b010, 4'h0);
        cyc("beq1_d", 4'd1,  0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b010, 4'h0);
        cyc("beq1_b", 4'd10, 1,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b010, 4'h1);

        // beq not taken
        set_in(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc("beq0_f", 4'd0,  1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b010, 4'h0);
        cyc("beq0_d", 4'd1,  0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b010, 4'h0);
        cyc("beq0_b", 4'd10, 0,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b010, 4'h1);

        // bne taken on Zero=0
        set_in(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cyc("bne_b", 4'd10, 1,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b010, 4'h1);

        // bge taken on GE=1
        set_in(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        cyc("bge_b", 4'd10, 1,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b010, 4'h1);

        // blt not taken on GE=1
        set_in(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        cyc("blt_b", 4'd10, 0,0,0,0, 2'b00,2'b10,2'b00, 0, 3'b010, 4'h1);

        // illegal opcode skipped in two cycles
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc("ill_f", 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b000, 4'h0);
        cyc("ill_d", 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b000, 4'h0);

        // sw, then reset in MEMWRITE
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc("sw_f",  4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b001, 4'h0);
        cyc("sw_d",  4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 0, 3'b001, 4'h0);
        cyc("sw_ma", 4'd2, 0,0,0,0, 2'b00,2'b10,2'b01, 0, 3'b001, 4'h0);
        look("sw_mw", 4'd5, 0,1,1,0, 2'b00,2'b00,2'b00, 0, 3'b001, 4'h0);
        reset = 1'b1;
        look("sw_rst", 4'd5, 0,1,0,0, 2'b00,2'b00,2'b00, 0, 3'b001, 4'h0);
        tick();
        look("rst_f", 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 0, 3'b001, 4'h0);
        reset = 1'b0;
        look("rel_f", 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 0, 3'b001, 4'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
